control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 29 ++
 rtl/control_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Control-sequencer bundle: instruction/handshake inputs and every datapath
// strobe. The sequencer uses the master modport and the datapath the slave modport.
interface control_sequencer_if #(
    parameter int BITS = 32
);
    logic [BITS-1:0] IR;
    logic            mem_ready;

    logic PCout, MARin, IncPC, RZin, RZout, PCin, Read, MDRin, MDRout, IRin;
    logic Gra, Grb, Grc, Rout, Rin, RYin, Cout;
    logic ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT;
    logic run, illegal;

    modport master (
        input  IR, mem_ready,
        output PCout, MARin, IncPC, RZin, RZout, PCin, Read, MDRin, MDRout, IRin,
        output Gra, Grb, Grc, Rout, Rin, RYin, Cout,
        output ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT,
        output run, illegal
    );

    modport slave (
        output IR, mem_ready,
        input  PCout, MARin, IncPC, RZin, RZout, PCin, Read, MDRin, MDRout, IRin,
        input  Gra, Grb, Grc, Rout, Rin, RYin, Cout,
        input  ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT,
        input  run, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control sequencer: T0-T5 micro-steps plus HALT,
// all strobes registered from the next state and a latched opcode.
module control_sequencer #(
    parameter int BITS = 32
) (
    input logic               clk,
    input logic               reset,
    control_sequencer_if.master bus
);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, HALT} state_t;
    typedef enum logic [1:0] {C_RTYPE, C_IMM, C_UNARY, C_OTHER} op_class_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    typedef struct packed {
        logic       pc_out;
        logic       mar_in;
        logic       inc_pc;
        logic       rz_in;
        logic       rz_out;
        logic       pc_in;
        logic       read;
        logic       mdr_in;
        logic       mdr_out;
        logic       ir_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_out;
        logic       r_in;
        logic       ry_in;
        logic       c_out;
        logic       run;
        logic [9:0] alu;  // {NOT, NEGATE, OR, AND, ROL, ROR, SHL, SHR, SUB, ADD}
    } strobes_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:  return C_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:       return C_IMM;
            OP_NEG, OP_NOT:                 return C_UNARY;
            default:                        return C_OTHER;
        endcase
    endfunction

    function automatic logic [9:0] alu_select(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI: return 10'b00_0000_0001;
            OP_SUB:          return 10'b00_0000_0010;
            OP_SHR:          return 10'b00_0000_0100;
            OP_SHL:          return 10'b00_0000_1000;
            OP_ROR:          return 10'b00_0001_0000;
            OP_ROL:          return 10'b00_0010_0000;
            OP_AND, OP_ANDI: return 10'b00_0100_0000;
            OP_OR, OP_ORI:   return 10'b00_1000_0000;
            OP_NEG:          return 10'b01_0000_0000;
            OP_NOT:          return 10'b10_0000_0000;
            default:         return '0;
        endcase
    endfunction

    // RZout/PCin of the fetch are not decoded here; they are qualified by
    // mem_ready at the output so the PC advances once per fetch.
    function automatic strobes_t decode(input state_t s, input logic [4:0] op);
        strobes_t  o;
        op_class_t c;
        o = '0;
        c = op_class(op);
        case (s)
            T0: begin
                o.pc_out = 1'b1;
                o.mar_in = 1'b1;
                o.inc_pc = 1'b1;
                o.rz_in  = 1'b1;
                o.run    = 1'b1;
            end
            T1: begin
                o.read   = 1'b1;
                o.mdr_in = 1'b1;
                o.run    = 1'b1;
            end
            T2: begin
                o.mdr_out = 1'b1;
                o.ir_in   = 1'b1;
                o.run     = 1'b1;
            end
            T3: begin
                o.run   = 1'b1;
                o.grb   = 1'b1;
                o.r_out = 1'b1;
                if (c == C_UNARY) begin
                    o.alu   = alu_select(op);
                    o.rz_in = 1'b1;
                end else begin
                    o.ry_in = 1'b1;
                end
            end
            T4: begin
                o.run = 1'b1;
                if (c == C_UNARY) begin
                    o.rz_out = 1'b1;
                    o.gra    = 1'b1;
                    o.r_in   = 1'b1;
                end else begin
                    o.alu   = alu_select(op);
                    o.rz_in = 1'b1;
                    if (c == C_RTYPE) begin
                        o.grc   = 1'b1;
                        o.r_out = 1'b1;
                    end else begin
                        o.c_out = 1'b1;
                    end
                end
            end
            T5: begin
                o.rz_out = 1'b1;
                o.gra    = 1'b1;
                o.r_in   = 1'b1;
                o.run    = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    state_t     state_q, state_d;
    strobes_t   outs_q, outs_d;
    logic [4:0] opcode_q, opcode_d;
    logic       illegal_q, illegal_d;
    logic       fetch_wait_q, fetch_wait_d;
    logic [4:0] ir_op;

    assign ir_op = bus.IR[BITS-1 -: 5];

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;
        case (state_q)
            // T0 with run low is the first cycle after reset: hold so that
            // the following cycle presents T0 with run high.
            T0: state_d = outs_q.run ? T1 : T0;
            T1: if (bus.mem_ready) state_d = T2;
            T2: begin
                opcode_d = ir_op;
                if (ir_op == OP_NOP) begin
                    state_d = T0;
                end else if (ir_op == OP_HALT) begin
                    state_d = HALT;
                end else if (op_class(ir_op) == C_OTHER) begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = T3;
                end
            end
            T3:      state_d = T4;
            T4:      state_d = (op_class(opcode_q) == C_UNARY) ? T0 : T5;
            T5:      state_d = T0;
            HALT:    state_d = HALT;
            default: state_d = T0;
        endcase
        outs_d       = decode(state_d, opcode_d);
        fetch_wait_d = (state_d == T1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= T0;
            outs_q       <= '0;
            opcode_q     <= '0;
            illegal_q    <= 1'b0;
            fetch_wait_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            outs_q       <= outs_d;
            opcode_q     <= opcode_d;
            illegal_q    <= illegal_d;
            fetch_wait_q <= fetch_wait_d;
        end
    end

    assign bus.PCout   = outs_q.pc_out;
    assign bus.MARin   = outs_q.mar_in;
    assign bus.IncPC   = outs_q.inc_pc;
    assign bus.RZin    = outs_q.rz_in;
    assign bus.RZout   = outs_q.rz_out | (fetch_wait_q & bus.mem_ready);
    assign bus.PCin    = outs_q.pc_in  | (fetch_wait_q & bus.mem_ready);
    assign bus.Read    = outs_q.read;
    assign bus.MDRin   = outs_q.mdr_in;
    assign bus.MDRout  = outs_q.mdr_out;
    assign bus.IRin    = outs_q.ir_in;
    assign bus.Gra     = outs_q.gra;
    assign bus.Grb     = outs_q.grb;
    assign bus.Grc     = outs_q.grc;
    assign bus.Rout    = outs_q.r_out;
    assign bus.Rin     = outs_q.r_in;
    assign bus.RYin    = outs_q.ry_in;
    assign bus.Cout    = outs_q.c_out;
    assign bus.ADD     = outs_q.alu[0];
    assign bus.SUB     = outs_q.alu[1];
    assign bus.SHR     = outs_q.alu[2];
    assign bus.SHL     = outs_q.alu[3];
    assign bus.ROR     = outs_q.alu[4];
    assign bus.ROL     = outs_q.alu[5];
    assign bus.AND     = outs_q.alu[6];
    assign bus.OR      = outs_q.alu[7];
    assign bus.NEGATE  = outs_q.alu[8];
    assign bus.NOT     = outs_q.alu[9];
    assign bus.run     = outs_q.run;
    assign bus.illegal = illegal_q;

endmodule
